// File: rtl/idu_ctrl_pkg.sv
// idu_ctrl_pkg: shared widths, decoder numbers and FSM state encodings for the decode controller
package idu_ctrl_pkg;
  localparam int IDU_ISA_WIDTH = 32;
  localparam int IDU_INST_NUM_WIDTH = 6;
  localparam int IDU_CNT_WIDTH = 32;
  localparam logic [IDU_INST_NUM_WIDTH-1:0] IDU_INV_NUM = 6'd0;
  localparam logic [IDU_INST_NUM_WIDTH-1:0] IDU_EBREAK_NUM = 6'd37;
  typedef enum logic [2:0] {
    IDU_CTRL_IDLE = 3'd0,
    IDU_CTRL_DEC  = 3'd1,
    IDU_CTRL_OUT  = 3'd2,
    IDU_CTRL_TRAP = 3'd3,
    IDU_CTRL_HALT = 3'd4
  } idu_ctrl_state_e;
endpackage

// File: rtl/idu_ctrl_cnt.sv
// idu_ctrl_cnt: saturating up-counter, cleared by rst, sticks at all-ones
//   clk, rst : clock, synchronous active-high reset
//   inc      : count one event this cycle
//   cnt      : current count
module idu_ctrl_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/idu_ctrl.sv
// idu_ctrl: decode-stage sequencer between IFU and EXU around an external decoder tree
//   ifu_valid/ifu_ready, inst_in, pc_in : instruction offer from IFU
//   dec_inst -> dec_num                 : loop through the external decoder tree
//   exu_valid/exu_ready, inst_num,
//   inst_out, pc_out                    : decoded instruction handed to EXU
//   flush                               : drop any held instruction
//   trap/trap_pc, halt                  : sticky invalid-instruction and ebreak stops
//   dec_count                           : saturating count of EXU handshakes
module idu_ctrl
  import idu_ctrl_pkg::*;
#(
  parameter int ISA_WIDTH = IDU_ISA_WIDTH,
  parameter int INST_NUM_WIDTH = IDU_INST_NUM_WIDTH,
  parameter logic [INST_NUM_WIDTH-1:0] INV_NUM = IDU_INV_NUM,
  parameter logic [INST_NUM_WIDTH-1:0] EBREAK_NUM = IDU_EBREAK_NUM,
  parameter int CNT_WIDTH = IDU_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ifu_valid,
  output logic                      ifu_ready,
  input  logic [ISA_WIDTH-1:0]      inst_in,
  input  logic [ISA_WIDTH-1:0]      pc_in,
  output logic [ISA_WIDTH-1:0]      dec_inst,
  input  logic [INST_NUM_WIDTH-1:0] dec_num,
  output logic                      exu_valid,
  input  logic                      exu_ready,
  output logic [INST_NUM_WIDTH-1:0] inst_num,
  output logic [ISA_WIDTH-1:0]      inst_out,
  output logic [ISA_WIDTH-1:0]      pc_out,
  input  logic                      flush,
  output logic                      trap,
  output logic                      halt,
  output logic [ISA_WIDTH-1:0]      trap_pc,
  output logic [CNT_WIDTH-1:0]      dec_count
);
  idu_ctrl_state_e state_q, state_d;
  logic [ISA_WIDTH-1:0] inst_q, pc_q, trap_pc_q;
  logic [INST_NUM_WIDTH-1:0] num_q;
  logic is_ebreak, is_inv, accept, handshake;
  assign is_ebreak = num_q == EBREAK_NUM;
  assign is_inv = dec_num == INV_NUM;
  // An ebreak in OUT never lets a new instruction in behind it: the pipe halts after it.
  assign ifu_ready = !flush && (state_q == IDU_CTRL_IDLE ||
                     (state_q == IDU_CTRL_OUT && exu_ready && !is_ebreak));
  assign accept = ifu_valid && ifu_ready;
  assign handshake = state_q == IDU_CTRL_OUT && exu_ready && !flush;
  assign exu_valid = state_q == IDU_CTRL_OUT;
  assign trap = state_q == IDU_CTRL_TRAP;
  assign halt = state_q == IDU_CTRL_HALT;
  assign dec_inst = inst_q;
  assign inst_out = inst_q;
  assign pc_out = pc_q;
  assign inst_num = num_q;
  assign trap_pc = trap_pc_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDU_CTRL_IDLE: state_d = accept ? IDU_CTRL_DEC : IDU_CTRL_IDLE;
      IDU_CTRL_DEC:  state_d = flush ? IDU_CTRL_IDLE : is_inv ? IDU_CTRL_TRAP : IDU_CTRL_OUT;
      IDU_CTRL_OUT:  state_d = flush ? IDU_CTRL_IDLE : !exu_ready ? IDU_CTRL_OUT :
                               is_ebreak ? IDU_CTRL_HALT : accept ? IDU_CTRL_DEC : IDU_CTRL_IDLE;
      IDU_CTRL_TRAP: state_d = IDU_CTRL_TRAP;
      IDU_CTRL_HALT: state_d = IDU_CTRL_HALT;
      default:       state_d = IDU_CTRL_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDU_CTRL_IDLE;
      inst_q <= '0;
      pc_q <= '0;
      num_q <= '0;
      trap_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        inst_q <= inst_in;
        pc_q <= pc_in;
      end
      if (state_q == IDU_CTRL_DEC && !flush) begin
        num_q <= dec_num;
        if (is_inv) trap_pc_q <= pc_q;
      end
    end
  end
  idu_ctrl_cnt #(.W(CNT_WIDTH)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(handshake),
    .cnt(dec_count)
  );
endmodule

// File: tb/tb_idu_ctrl.sv
// tb_idu_ctrl: directed vector table plus randomized run against a transaction-level model
module tb_idu_ctrl;
  import idu_ctrl_pkg::*;
  localparam logic [31:0] ADDI = 32'h00500093, EBRK = 32'h00100073, BAD = 32'hffffffff;
  localparam logic [31:0] P0 = 32'h80000000;
  logic clk = 1'b0, rst, ifu_valid, ifu_ready, exu_valid, exu_ready, flush, trap, halt;
  logic [31:0] inst_in, pc_in, dec_inst, inst_out, pc_out, trap_pc, dec_count;
  logic [5:0] dec_num, inst_num;
  logic inc3;
  logic [2:0] cnt3;
  int checks = 0, errors = 0;

  idu_ctrl dut (
    .clk(clk), .rst(rst), .ifu_valid(ifu_valid), .ifu_ready(ifu_ready),
    .inst_in(inst_in), .pc_in(pc_in), .dec_inst(dec_inst), .dec_num(dec_num),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .inst_num(inst_num),
    .inst_out(inst_out), .pc_out(pc_out), .flush(flush), .trap(trap),
    .halt(halt), .trap_pc(trap_pc), .dec_count(dec_count)
  );
  idu_ctrl_cnt #(.W(3)) u_sat (.clk(clk), .rst(rst), .inc(inc3), .cnt(cnt3));

  always #5 clk = ~clk;

  // Stand-in for the external decoder tree.
  function automatic logic [5:0] tb_dec(logic [31:0] i);
    logic [5:0] x;
    x = i[12:7];
    if (i == EBRK) return IDU_EBREAK_NUM;
    if (i[6:0] == 7'h7f) return IDU_INV_NUM;
    if (i == ADDI) return 6'd11;
    return (x == IDU_INV_NUM || x == IDU_EBREAK_NUM) ? 6'd1 : x;
  endfunction
  always_comb dec_num = tb_dec(dec_inst);

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  typedef struct {
    logic r, v, f, er;
    logic [31:0] inst, pc;
    logic ir, ev;
    logic [5:0] num;
    logic [31:0] io, po, cnt;
    logic tr, hl;
    logic [31:0] tpc;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mk(logic r, v, f, er, logic [31:0] inst, pc, logic ir, ev,
                              logic [5:0] num, logic [31:0] io, po, cnt, logic tr, hl,
                              logic [31:0] tpc);
    vec_t t;
    t.r = r; t.v = v; t.f = f; t.er = er; t.inst = inst; t.pc = pc; t.ir = ir; t.ev = ev;
    t.num = num; t.io = io; t.po = po; t.cnt = cnt; t.tr = tr; t.hl = hl; t.tpc = tpc;
    return t;
  endfunction

  // transaction-level reference state
  logic m_have, m_age, m_trap, m_halt;
  logic [31:0] m_inst, m_pc, m_cnt, m_tpc;

  initial begin
    logic [31:0] b[5];
    logic [31:0] r32;
    logic e_ev, e_ir;
    rst = 1; ifu_valid = 0; flush = 0; exu_ready = 0; inst_in = 0; pc_in = 0; inc3 = 0;
    repeat (2) @(negedge clk);
    // single op with 5 cycles of backpressure
    vq.push_back(mk(0,1,0,0, ADDI,P0, 1,0,0,0,0,0, 0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,     0,0,0,0,0,0, 0,0,0));
    for (int i = 0; i < 5; i++) vq.push_back(mk(0,0,0,0, 0,0, 0,1,11,ADDI,P0,0, 0,0,0));
    vq.push_back(mk(0,0,0,1, 0,0,     1,1,11,ADDI,P0,0, 0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,     1,0,0,0,0,1, 0,0,0));
    // flush in DEC
    vq.push_back(mk(0,1,0,0, 32'h00a00113,P0+4, 1,0,0,0,0,1, 0,0,0));
    vq.push_back(mk(0,0,1,0, 0,0,     0,0,0,0,0,1, 0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,     1,0,0,0,0,1, 0,0,0));
    // flush in OUT with exu_ready
    vq.push_back(mk(0,1,0,0, 32'h01400193,P0+8, 1,0,0,0,0,1, 0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,     0,0,0,0,0,1, 0,0,0));
    vq.push_back(mk(0,0,1,1, 0,0,     0,1,tb_dec(32'h01400193),32'h01400193,P0+8,1, 0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,     1,0,0,0,0,1, 0,0,0));
    // back-to-back, four instructions
    for (int k = 0; k < 5; k++) b[k] = 32'h00108093 + (k << 20);
    vq.push_back(mk(0,1,0,1, b[0],P0+32'h100, 1,0,0,0,0,1, 0,0,0));
    for (int k = 0; k < 4; k++) begin
      vq.push_back(mk(0,k<3,0,1, b[k+1],P0+32'h100+4*(k+1), 0,0,0,0,0,1+k, 0,0,0));
      vq.push_back(mk(0,k<3,0,1, b[k+1],P0+32'h100+4*(k+1), 1,1,tb_dec(b[k]),b[k],
                      P0+32'h100+4*k,1+k, 0,0,0));
    end
    vq.push_back(mk(0,0,0,0, 0,0,     1,0,0,0,0,5, 0,0,0));
    // ebreak: halt after handshake, ifu and flush ignored, rst clears
    vq.push_back(mk(0,1,0,0, EBRK,P0+32'h200, 1,0,0,0,0,5, 0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,     0,0,0,0,0,5, 0,0,0));
    vq.push_back(mk(0,1,0,1, ADDI,P0, 0,1,IDU_EBREAK_NUM,EBRK,P0+32'h200,5, 0,0,0));
    vq.push_back(mk(0,1,0,1, ADDI,P0, 0,0,0,0,0,6, 0,1,0));
    vq.push_back(mk(0,1,1,1, ADDI,P0, 0,0,0,0,0,6, 0,1,0));
    vq.push_back(mk(1,0,0,0, 0,0,     0,0,0,0,0,6, 0,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,     1,0,0,0,0,0, 0,0,0));
    // invalid instruction: trap sticky until rst
    vq.push_back(mk(0,1,0,0, BAD,P0+32'h10, 1,0,0,0,0,0, 0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,     0,0,0,0,0,0, 0,0,0));
    vq.push_back(mk(0,1,0,0, ADDI,P0, 0,0,0,0,0,0, 1,0,P0+32'h10));
    vq.push_back(mk(0,1,1,1, ADDI,P0, 0,0,0,0,0,0, 1,0,P0+32'h10));
    vq.push_back(mk(1,0,0,0, 0,0,     0,0,0,0,0,0, 1,0,P0+32'h10));
    vq.push_back(mk(0,0,0,0, 0,0,     1,0,0,0,0,0, 0,0,0));
    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].r; ifu_valid = vq[i].v; flush = vq[i].f; exu_ready = vq[i].er;
      inst_in = vq[i].inst; pc_in = vq[i].pc;
      #1;
      chk($sformatf("v%0d_ifu_ready", i), ifu_ready, vq[i].ir);
      chk($sformatf("v%0d_exu_valid", i), exu_valid, vq[i].ev);
      chk($sformatf("v%0d_count", i), dec_count, vq[i].cnt);
      chk($sformatf("v%0d_trap", i), trap, vq[i].tr);
      chk($sformatf("v%0d_halt", i), halt, vq[i].hl);
      chk($sformatf("v%0d_trap_pc", i), trap_pc, vq[i].tpc);
      if (vq[i].ev) begin
        chk($sformatf("v%0d_inst_num", i), inst_num, vq[i].num);
        chk($sformatf("v%0d_inst_out", i), inst_out, vq[i].io);
        chk($sformatf("v%0d_pc_out", i), pc_out, vq[i].po);
      end
    end
    // saturating counter boundary
    @(negedge clk); rst = 1; ifu_valid = 0; flush = 0; exu_ready = 0;
    @(negedge clk); rst = 0; inc3 = 1;
    for (int k = 0; k < 10; k++) begin
      #1 chk($sformatf("sat%0d", k), cnt3, (k > 7) ? 7 : k);
      @(negedge clk);
    end
    inc3 = 0;
    // randomized run against the model
    rst = 1;
    @(negedge clk);
    m_have = 0; m_age = 0; m_trap = 0; m_halt = 0; m_inst = 0; m_pc = 0; m_cnt = 0; m_tpc = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      ifu_valid = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 19) == 0);
      exu_ready = ($urandom_range(0, 9) < 6);
      pc_in = $urandom & 32'hfffffffc;
      r32 = $urandom;
      case ($urandom_range(0, 39))
        0: r32[6:0] = 7'h7f;
        1: r32 = EBRK;
        default: begin
          if (r32[6:0] == 7'h7f) r32[6:0] = 7'h13;
          if (r32 == EBRK) r32 = ADDI;
        end
      endcase
      inst_in = r32;
      #1;
      e_ev = m_have && m_age;
      e_ir = !flush && !m_trap && !m_halt &&
             (!m_have || (e_ev && exu_ready && tb_dec(m_inst) != IDU_EBREAK_NUM));
      chk("rnd_ifu_ready", ifu_ready, e_ir);
      chk("rnd_exu_valid", exu_valid, e_ev);
      chk("rnd_trap", trap, m_trap);
      chk("rnd_halt", halt, m_halt);
      chk("rnd_count", dec_count, m_cnt);
      if (m_have) chk("rnd_dec_inst", dec_inst, m_inst);
      if (e_ev) begin
        chk("rnd_inst_num", inst_num, tb_dec(m_inst));
        chk("rnd_inst_out", inst_out, m_inst);
        chk("rnd_pc_out", pc_out, m_pc);
      end
      if (m_trap) chk("rnd_trap_pc", trap_pc, m_tpc);
      if (rst) begin
        m_have = 0; m_trap = 0; m_halt = 0; m_cnt = 0; m_tpc = 0;
      end else if (m_trap || m_halt) begin
      end else if (flush) begin
        m_have = 0;
      end else begin
        if (m_have && !m_age) begin
          if (tb_dec(m_inst) == IDU_INV_NUM) begin
            m_trap = 1; m_tpc = m_pc; m_have = 0;
          end else m_age = 1;
        end else if (e_ev && exu_ready) begin
          if (m_cnt != 32'hffffffff) m_cnt++;
          if (tb_dec(m_inst) == IDU_EBREAK_NUM) m_halt = 1;
          m_have = 0;
        end
        if (ifu_valid && e_ir) begin
          m_have = 1; m_age = 0; m_inst = inst_in; m_pc = pc_in;
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
